// File: rtl/pll_sup_pkg.sv
// Shared types and helpers for the PLL reset supervisor.
// State encodings are plain constants so legacy tools can decode the state bus directly.
package pll_sup_pkg;

   localparam int RETRY_W = 3;
   localparam int LOSS_W  = 8;

   typedef logic [2:0] state_t;

   localparam state_t ST_ASSERT_RST = 3'd0;
   localparam state_t ST_WAIT_LOCK  = 3'd1;
   localparam state_t ST_STABLE     = 3'd2;
   localparam state_t ST_RUN        = 3'd3;
   localparam state_t ST_FAULT      = 3'd4;

   function automatic logic [LOSS_W-1:0] sat_inc(input logic [LOSS_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic single-bit two-flop synchronizer; 2-cycle latency, no backpressure.
// Both flops clear on synchronous reset so a stale high never leaks out after reset.
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pll_reset_supervisor.sv
// PLL reset pulse / lock-wait / retry supervisor; release is sync(2) + 1 + LOCK_STABLE_CYCLES after lock.
// Moore outputs straight from the state register; no flow control on any port.
module pll_reset_supervisor
   import pll_sup_pkg::*;
#(
   parameter int RST_PULSE_CYCLES    = 16,
   parameter int LOCK_TIMEOUT_CYCLES = 50000,
   parameter int LOCK_STABLE_CYCLES  = 1024,
   parameter int MAX_RETRIES         = 4,
   parameter int CNT_W               = 16
) (
   input  logic                refclk,
   input  logic                rst,
   input  logic                pll_locked,
   input  logic                retry_req,
   output logic                pll_rst,
   output logic                sys_rst,
   output logic                lock_ok,
   output logic                fault,
   output logic [RETRY_W-1:0]  retry_count,
   output logic [LOSS_W-1:0]   loss_count
);

   localparam logic [CNT_W-1:0]   PULSE_LOAD   = CNT_W'(RST_PULSE_CYCLES - 1);
   localparam logic [CNT_W-1:0]   TIMEOUT_LOAD = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0]   STABLE_LOAD  = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic               cnt_zero;
   logic               locked_s;
   logic [RETRY_W-1:0] retry_next;

   sync_2ff u_lock_sync (
      .clk (refclk),
      .rst (rst),
      .d   (pll_locked),
      .q   (locked_s)
   );

   assign cnt_zero   = (cnt == '0);
   assign retry_next = retry_count + 1'b1;

   // One down-counter serves all timed states; every transition reloads it for the next state.
   always_ff @(posedge refclk) begin
      if (rst) begin
         state       <= ST_ASSERT_RST;
         cnt         <= PULSE_LOAD;
         retry_count <= '0;
         loss_count  <= '0;
      end else begin
         case (state)
            ST_ASSERT_RST: begin
               if (cnt_zero) begin
                  state <= ST_WAIT_LOCK;
                  cnt   <= TIMEOUT_LOAD;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_WAIT_LOCK: begin
               if (locked_s) begin
                  state <= ST_STABLE;
                  cnt   <= STABLE_LOAD;
               end else if (cnt_zero) begin
                  retry_count <= retry_next;
                  state       <= (retry_next == RETRY_MAX) ? ST_FAULT : ST_ASSERT_RST;
                  cnt         <= PULSE_LOAD;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_STABLE: begin
               // A dropout restarts the lock wait without charging a retry.
               if (!locked_s) begin
                  state <= ST_WAIT_LOCK;
                  cnt   <= TIMEOUT_LOAD;
               end else if (cnt_zero) begin
                  state       <= ST_RUN;
                  retry_count <= '0;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_RUN: begin
               if (!locked_s) begin
                  state      <= ST_ASSERT_RST;
                  cnt        <= PULSE_LOAD;
                  loss_count <= sat_inc(loss_count);
               end
            end
            ST_FAULT: begin
               if (retry_req) begin
                  state       <= ST_ASSERT_RST;
                  cnt         <= PULSE_LOAD;
                  retry_count <= '0;
               end
            end
            default: begin
               state <= ST_ASSERT_RST;
               cnt   <= PULSE_LOAD;
            end
         endcase
      end
   end

   assign pll_rst = (state == ST_ASSERT_RST) || (state == ST_FAULT);
   assign sys_rst = (state != ST_RUN);
   assign lock_ok = (state == ST_RUN);
   assign fault   = (state == ST_FAULT);

endmodule
